rvfi_trace_monitor: RTL and testbench

//  Consumer side of the core's RVFI port (NRET=1). Checks each retired instruction for protocol and

---
 rtl/rvfi_trace_monitor.sv | 135 +++++++++++++
 tb/tb_rvfi_trace_monitor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rvfi_trace_monitor.sv
// rtl/rvfi_trace_monitor.sv - RVFI retire checker with sticky error flags and trace record FIFO
module rvfi_trace_monitor #(
  parameter int XLEN          = 32,
  parameter int ILEN          = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int STOP_ON_ERROR = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rvfi_valid,
  input  logic [63:0]              rvfi_order,
  input  logic [ILEN-1:0]          rvfi_insn,
  input  logic                     rvfi_trap,
  input  logic                     rvfi_halt,
  input  logic [4:0]               rvfi_rd_addr,
  input  logic [XLEN-1:0]          rvfi_rd_wdata,
  input  logic [XLEN-1:0]          rvfi_pc_rdata,
  input  logic [XLEN-1:0]          rvfi_pc_wdata,
  input  logic [XLEN/8-1:0]        rvfi_mem_rmask,
  input  logic [XLEN/8-1:0]        rvfi_mem_wmask,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [2*XLEN+ILEN+4:0]   trace_data,
  output logic [5:0]               err_flags,
  output logic [63:0]              err_order,
  output logic                     halted,
  output logic [15:0]              dropped
);

  localparam int RW = 2*XLEN + ILEN + 5;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {WAIT_FIRST, RUN, HALTED, STOPPED} state_t;

  state_t          state, state_next;
  logic [63:0]     exp_order;
  logic [XLEN-1:0] exp_pc;
  logic [5:0]      err_now;
  logic            stop_now;

  logic [RW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, wr_next, rd_next;
  logic [RW-1:0]   push_data, head_next;
  logic            push_req, wr_en, pop, full, drop;

  // Per-retire consistency checks against the expected order/PC chain
  always_comb begin
    err_now = '0;
    if (rvfi_valid) begin
      err_now[0] = (rvfi_order != exp_order);
      err_now[1] = (state == RUN) && (rvfi_pc_rdata != exp_pc);
      err_now[2] = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0);
      err_now[3] = (state == HALTED);
      err_now[4] = (|rvfi_mem_rmask) && (|rvfi_mem_wmask);
      err_now[5] = rvfi_trap;
    end
  end

  assign stop_now = (STOP_ON_ERROR != 0) && (|err_now);

  // Next-state: errors win over halt; HALTED and STOPPED only leave on reset
  always_comb begin
    state_next = state;
    case (state)
      WAIT_FIRST: if (rvfi_valid) state_next = stop_now ? STOPPED : RUN;
      RUN: begin
        if (rvfi_valid) begin
          if (stop_now)       state_next = STOPPED;
          else if (rvfi_halt) state_next = HALTED;
        end
      end
      default: state_next = state;
    endcase
  end

  // State, expected-order/PC tracking and sticky error capture
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= WAIT_FIRST;
      exp_order <= '0;
      exp_pc    <= '0;
      err_flags <= '0;
      err_order <= '0;
    end else begin
      state <= state_next;
      if (rvfi_valid) begin
        exp_order <= rvfi_order + 64'd1;
        exp_pc    <= rvfi_pc_wdata;
      end
      err_flags <= err_flags | err_now;
      if ((err_flags == 6'd0) && (|err_now)) err_order <= rvfi_order;
    end
  end

  assign halted      = (state == HALTED);
  assign push_data   = {rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata};
  assign push_req    = rvfi_valid && ((state == WAIT_FIRST) || (state == RUN));
  assign trace_valid = (rd_ptr != wr_ptr);
  assign pop         = trace_valid && trace_ready;
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en       = push_req && (!full || pop);
  assign drop        = push_req && full && !pop;
  assign wr_next     = wr_ptr + PW'(wr_en);
  assign rd_next     = rd_ptr + PW'(pop);

  // Head after this edge: a push into an emptied FIFO becomes the head directly
  always_comb begin
    head_next = '0;
    if (rd_next == wr_next)            head_next = '0;
    else if (wr_en && rd_next == wr_ptr) head_next = push_data;
    else                               head_next = mem[rd_next[AW-1:0]];
  end

  // Record storage; contents are don't-care until pointed at, so no reset
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // FIFO pointers, registered head record and saturating drop counter
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      trace_data <= '0;
      dropped    <= '0;
    end else begin
      wr_ptr     <= wr_next;
      rd_ptr     <= rd_next;
      trace_data <= head_next;
      if (drop && (dropped != 16'hFFFF)) dropped <= dropped + 16'd1;
    end
  end

endmodule

// File: tb/tb_rvfi_trace_monitor.sv
// tb/tb_rvfi_trace_monitor.sv - directed self-checking bench for rvfi_trace_monitor
module tb_rvfi_trace_monitor;

  logic         clk = 1'b0;
  logic         reset;
  logic         rvfi_valid;
  logic [63:0]  rvfi_order;
  logic [31:0]  rvfi_insn;
  logic         rvfi_trap;
  logic         rvfi_halt;
  logic [4:0]   rvfi_rd_addr;
  logic [31:0]  rvfi_rd_wdata;
  logic [31:0]  rvfi_pc_rdata;
  logic [31:0]  rvfi_pc_wdata;
  logic [3:0]   rvfi_mem_rmask;
  logic [3:0]   rvfi_mem_wmask;
  logic         trace_valid;
  logic         trace_ready;
  logic [100:0] trace_data;
  logic [5:0]   err_flags;
  logic [63:0]  err_order;
  logic         halted;
  logic [15:0]  dropped;

  int vec_cnt  = 0;
  int miscmp   = 0;
  logic [100:0] got [$];

  rvfi_trace_monitor #(.XLEN(32), .ILEN(32), .FIFO_DEPTH(8), .STOP_ON_ERROR(1)) dut (
    .clock(clk), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .err_flags(err_flags), .err_order(err_order), .halted(halted), .dropped(dropped)
  );

  always #5 clk = ~clk;

  // Sink: capture every record that will be popped at the coming edge
  always @(negedge clk) begin
    if (reset && trace_valid && trace_ready) got.push_back(trace_data);
  end

  function automatic logic [31:0] insn_of(input int i);
    return 32'h00000093 + (i << 20);
  endfunction

  function automatic logic [100:0] rec(input logic [31:0] pc, input int i);
    return {pc, insn_of(i), 5'd1, 32'hA0 + i};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic retire(input logic [63:0] order, input logic [31:0] pc, input logic [31:0] pcw,
                        input int i, input logic [4:0] rd, input logic [31:0] wd,
                        input logic [3:0] rm, input logic [3:0] wm,
                        input logic trap, input logic halt);
    rvfi_valid = 1'b1; rvfi_order = order; rvfi_pc_rdata = pc; rvfi_pc_wdata = pcw;
    rvfi_insn = insn_of(i); rvfi_rd_addr = rd; rvfi_rd_wdata = wd;
    rvfi_mem_rmask = rm; rvfi_mem_wmask = wm; rvfi_trap = trap; rvfi_halt = halt;
    @(posedge clk); #1;
    rvfi_valid = 1'b0; rvfi_trap = 1'b0; rvfi_halt = 1'b0;
  endtask

  task automatic retire_simple(input int i, input logic [31:0] pc);
    retire(64'(i), pc, pc + 32'd4, i, 5'd1, 32'hA0 + i, 4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    got.delete();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rvfi_valid = 0; rvfi_order = 0; rvfi_insn = 0; rvfi_trap = 0; rvfi_halt = 0;
    rvfi_rd_addr = 0; rvfi_rd_wdata = 0; rvfi_pc_rdata = 0; rvfi_pc_wdata = 0;
    rvfi_mem_rmask = 0; rvfi_mem_wmask = 0; trace_ready = 1'b1; reset = 1'b0;

    // reset state
    do_reset();
    chk("rst_valid", 128'(trace_valid), 128'd0);
    chk("rst_data", 128'(trace_data), 128'd0);
    chk("rst_flags", 128'(err_flags), 128'd0);
    chk("rst_order", 128'(err_order), 128'd0);
    chk("rst_halted", 128'(halted), 128'd0);
    chk("rst_dropped", 128'(dropped), 128'd0);

    // T1: five clean chained retires drain straight through
    for (int i = 0; i < 5; i++) retire_simple(i, 32'(4 * i));
    idle(3);
    chk("t1_count", 128'(got.size()), 128'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("t1_rec%0d", i), 128'(got[i]), 128'(rec(32'(4 * i), i)));
    chk("t1_flags", 128'(err_flags), 128'd0);
    chk("t1_dropped", 128'(dropped), 128'd0);
    chk("t1_empty", 128'(trace_valid), 128'd0);

    // T2: order gap 0,1,3 -> order error, stop recording
    do_reset();
    retire_simple(0, 32'd0);
    retire_simple(1, 32'd4);
    chk("t2_flags_pre", 128'(err_flags), 128'd0);
    retire(64'd3, 32'd8, 32'd12, 3, 5'd1, 32'hA3, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("t2_flags", 128'(err_flags), 128'h1);
    chk("t2_err_order", 128'(err_order), 128'd3);
    retire(64'd4, 32'd12, 32'd16, 4, 5'd1, 32'hA4, 4'h0, 4'h0, 1'b0, 1'b0);
    idle(3);
    chk("t2_count", 128'(got.size()), 128'd3);
    chk("t2_rec2", 128'(got[2]), 128'(rec(32'd8, 3)));
    chk("t2_flags_post", 128'(err_flags), 128'h1);

    // T3: PC chain break, then x0 write
    do_reset();
    retire(64'd0, 32'd0, 32'h100, 0, 5'd1, 32'hA0, 4'h0, 4'h0, 1'b0, 1'b0);
    retire(64'd1, 32'h104, 32'h108, 1, 5'd1, 32'hA1, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("t3_pc_flag", 128'(err_flags), 128'h2);
    chk("t3_err_order", 128'(err_order), 128'd1);
    retire(64'd2, 32'h108, 32'h10C, 2, 5'd0, 32'h5, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("t3_x0_flag", 128'(err_flags), 128'h6);
    chk("t3_err_order_kept", 128'(err_order), 128'd1);

    // T4: sink stalled, 10 retires into 8 entries
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) retire_simple(i, 32'(4 * i));
    chk("t4_dropped", 128'(dropped), 128'd2);
    chk("t4_valid", 128'(trace_valid), 128'd1);
    chk("t4_head_stable", 128'(trace_data), 128'(rec(32'd0, 0)));
    trace_ready = 1'b1;
    idle(12);
    chk("t4_count", 128'(got.size()), 128'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("t4_rec%0d", i), 128'(got[i]), 128'(rec(32'(4 * i), i)));
    chk("t4_empty", 128'(trace_valid), 128'd0);
    chk("t4_data_zero", 128'(trace_data), 128'd0);

    // T5: halt, then a post-halt retire
    do_reset();
    retire_simple(0, 32'd0);
    retire(64'd1, 32'd4, 32'd8, 1, 5'd1, 32'hA1, 4'h0, 4'h0, 1'b0, 1'b1);
    chk("t5_halted", 128'(halted), 128'd1);
    chk("t5_flags_clean", 128'(err_flags), 128'd0);
    retire_simple(2, 32'd8);
    idle(3);
    chk("t5_posthalt_flag", 128'(err_flags), 128'h8);
    chk("t5_err_order", 128'(err_order), 128'd2);
    chk("t5_count", 128'(got.size()), 128'd2);
    chk("t5_still_halted", 128'(halted), 128'd1);

    // T7: load+store mask overlap, then trap
    do_reset();
    retire(64'd0, 32'd0, 32'd4, 0, 5'd1, 32'hA0, 4'hF, 4'h1, 1'b0, 1'b0);
    chk("t7_mask_flag", 128'(err_flags), 128'h10);
    chk("t7_err_order", 128'(err_order), 128'd0);
    retire(64'd1, 32'd4, 32'd8, 1, 5'd1, 32'hA1, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("t7_trap_flag", 128'(err_flags), 128'h30);

    // T6: reset pulse mid-drain clears everything
    do_reset();
    trace_ready = 1'b0;
    retire_simple(0, 32'd0);
    retire_simple(1, 32'd4);
    retire(64'd2, 32'd8, 32'd12, 2, 5'd1, 32'hA2, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("t6_pre_flags", 128'(err_flags), 128'h20);
    trace_ready = 1'b1;
    do_reset();
    chk("t6_valid", 128'(trace_valid), 128'd0);
    chk("t6_data", 128'(trace_data), 128'd0);
    chk("t6_flags", 128'(err_flags), 128'd0);
    chk("t6_err_order", 128'(err_order), 128'd0);
    chk("t6_dropped", 128'(dropped), 128'd0);
    retire_simple(0, 32'h40);
    idle(3);
    chk("t6_clean_flags", 128'(err_flags), 128'd0);
    chk("t6_count", 128'(got.size()), 128'd1);
    chk("t6_rec0", 128'(got[0]), 128'(rec(32'h40, 0)));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
